beta_shift_sched: RTL

// - Shares one iterative shift unit between two requesters (rq0, rq1) in the execute stage.
// - Round-robin arbitration, operand capture, and shift unit sequencing via en/busy.
// - Amounts 0 and 1 are resolved locally; the shift unit is used only for amounts >= 2.
// - One operation in flight. Result is held until the consumer takes it.

---
 rtl/beta_pkg.sv | 17 +
 rtl/beta_rr_arb2.sv | 30 +++
 rtl/beta_shift_sched.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/beta_pkg.sv
// Shared types for the beta execute-stage blocks.
// Shift modes and the shift scheduler states.
package beta_pkg;

  typedef enum logic [1:0] {
    SHIFT_LEFT   = 2'd0,
    SHIFT_RIGHT  = 2'd1,
    SHIFT_ARIGHT = 2'd2
  } shift_mode_t;

  typedef enum logic [1:0] {
    SCH_IDLE = 2'd0,
    SCH_RUN  = 2'd1,
    SCH_RESP = 2'd2
  } shift_sched_state_t;

endpackage

// File: rtl/beta_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
// On a tie the requester that did not win last time is chosen.
module beta_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic both;

  assign both = &req;

  // pick the winner index, then expand it to one-hot
  always_comb begin
    gnt_id = 1'b0;
    gnt    = 2'b00;
    unique case (1'b1)
      both:               gnt_id = ~last_grant;
      req[0] && !req[1]:  gnt_id = 1'b0;
      req[1] && !req[0]:  gnt_id = 1'b1;
      default:            gnt_id = 1'b0;
    endcase
    if (en && |req) begin
      gnt = gnt_id ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/beta_shift_sched.sv
// Schedules two requesters onto one iterative shift unit.
// Amounts 0 and 1 finish locally; larger ones use the unit.
module beta_shift_sched
  import beta_pkg::*;
#(
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 rq0_valid_i,
  output logic                 rq0_ready_o,
  input  logic [DataWidth-1:0] rq0_operand_a_i,
  input  logic [4:0]           rq0_operand_b_i,
  input  logic [1:0]           rq0_mode_i,
  input  logic                 rq1_valid_i,
  output logic                 rq1_ready_o,
  input  logic [DataWidth-1:0] rq1_operand_a_i,
  input  logic [4:0]           rq1_operand_b_i,
  input  logic [1:0]           rq1_mode_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_id_o,
  output logic [DataWidth-1:0] rsp_result_o,
  input  logic                 flush_i,
  output logic                 shu_en_o,
  output logic [DataWidth-1:0] shu_operand_a_o,
  output logic [4:0]           shu_operand_b_o,
  output logic [1:0]           shu_mode_o,
  input  logic                 shu_busy_i,
  input  logic [DataWidth-1:0] shu_result_i
);

  function automatic logic [DataWidth-1:0] shift_one(
    input logic [DataWidth-1:0] a,
    input logic [1:0]           m
  );
    logic [DataWidth-1:0] r;
    unique case (m)
      SHIFT_RIGHT:  r = a >> 1;
      SHIFT_ARIGHT: r = {a[DataWidth-1], a[DataWidth-1:1]};
      default:      r = a << 1;
    endcase
    return r;
  endfunction

  shift_sched_state_t state_q, state_d;

  logic                 last_grant_q;
  logic                 seen_busy_q;
  logic [DataWidth-1:0] a_q;
  logic [4:0]           b_q;
  logic [1:0]           mode_q;
  logic                 id_q;
  logic [DataWidth-1:0] res_q;

  logic                 arb_en;
  logic [1:0]           gnt;
  logic                 gnt_id;
  logic                 accept;
  logic                 run_done;
  logic [DataWidth-1:0] sel_a;
  logic [4:0]           sel_b;
  logic [1:0]           sel_mode;

  assign arb_en = (state_q == SCH_IDLE) && !flush_i;

  beta_rr_arb2 u_arb (
    .req        ({rq1_valid_i, rq0_valid_i}),
    .last_grant (last_grant_q),
    .en         (arb_en),
    .gnt        (gnt),
    .gnt_id     (gnt_id)
  );

  assign accept   = |gnt;
  assign sel_a    = gnt_id ? rq1_operand_a_i : rq0_operand_a_i;
  assign sel_b    = gnt_id ? rq1_operand_b_i : rq0_operand_b_i;
  assign sel_mode = gnt_id ? rq1_mode_i : rq0_mode_i;
  assign run_done = seen_busy_q && !shu_busy_i;

  // next state; flush wins over every transition
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SCH_IDLE: begin
        if (accept) begin
          state_d = (sel_b < 5'd2) ? SCH_RESP : SCH_RUN;
        end
      end
      SCH_RUN: begin
        if (run_done) state_d = SCH_RESP;
      end
      SCH_RESP: begin
        if (rsp_ready_i) state_d = SCH_IDLE;
      end
      default: state_d = SCH_IDLE;
    endcase
    if (flush_i) state_d = SCH_IDLE;
  end

  // state register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= SCH_IDLE;
    else         state_q <= state_d;
  end

  // operand capture, local result, unit handshake tracking
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      last_grant_q <= 1'b1;
      seen_busy_q  <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      mode_q       <= '0;
      id_q         <= 1'b0;
      res_q        <= '0;
    end else begin
      if (accept) begin
        a_q          <= sel_a;
        b_q          <= sel_b;
        mode_q       <= sel_mode;
        id_q         <= gnt_id;
        last_grant_q <= gnt_id;
        seen_busy_q  <= 1'b0;
        if (sel_b == 5'd0)      res_q <= sel_a;
        else if (sel_b == 5'd1) res_q <= shift_one(sel_a, sel_mode);
      end
      if (state_q == SCH_RUN) begin
        if (shu_busy_i) seen_busy_q <= 1'b1;
        if (run_done && !flush_i) res_q <= shu_result_i;
      end
    end
  end

  assign rq0_ready_o     = gnt[0];
  assign rq1_ready_o     = gnt[1];
  assign rsp_valid_o     = (state_q == SCH_RESP);
  assign rsp_id_o        = id_q;
  assign rsp_result_o    = res_q;
  assign shu_en_o        = (state_q == SCH_RUN);
  assign shu_operand_a_o = a_q;
  assign shu_operand_b_o = b_q;
  assign shu_mode_o      = mode_q;

endmodule
